// File: rtl/audio_codec_link_if.sv
`default_nettype none
// ==================================================================
// audio_codec_link_if : mixer-side sample bus and codec pins of the link
// Rev 1.0
// ==================================================================
interface audio_codec_link_if #(
  parameter int SAMPLE_BITS = 16
);
  logic [SAMPLE_BITS-1:0] audio_output;
  logic                   sample_req;
  logic [SAMPLE_BITS-1:0] audio_input;
  logic                   sample_end;
  logic                   channel;
  logic                   AUD_BCLK;
  logic                   AUD_DACLRCK;
  logic                   AUD_ADCLRCK;
  logic                   AUD_DACDAT;
  logic                   AUD_ADCDAT;

  // Mixer and board codec side
  modport master (
    output audio_output, AUD_ADCDAT,
    input  sample_req, audio_input, sample_end, channel,
           AUD_BCLK, AUD_DACLRCK, AUD_ADCLRCK, AUD_DACDAT
  );

  // Link (DUT) side
  modport slave (
    input  audio_output, AUD_ADCDAT,
    output sample_req, audio_input, sample_end, channel,
           AUD_BCLK, AUD_DACLRCK, AUD_ADCLRCK, AUD_DACDAT
  );
endinterface
`default_nettype wire

// File: rtl/audio_codec_link.sv
`default_nettype none
// ==================================================================
// audio_codec_link : left-justified codec link; option CODEC_LOOPBACK_EN
// Rev 1.0
// ==================================================================
module audio_codec_link #(
  parameter int SAMPLE_BITS = 16,
  parameter int SLOT_BITS   = 32,
  parameter int BCLK_HALF   = 4
) (
  input  logic clk,
  input  logic reset,
`ifdef CODEC_LOOPBACK_EN
  input  logic loopback,
`endif
  audio_codec_link_if.slave bus
);

  localparam int c_DW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int c_BW = $clog2(SLOT_BITS);
  localparam logic [c_DW-1:0] c_DIV_LAST  = c_DW'(BCLK_HALF - 1);
  localparam logic [c_BW-1:0] c_SLOT_LAST = c_BW'(SLOT_BITS - 1);
  localparam logic [c_BW-1:0] c_REQ_AT    = c_BW'(SLOT_BITS - 2);
  localparam logic [c_BW-1:0] c_RX_BITS   = c_BW'(SAMPLE_BITS);
  localparam logic [c_BW-1:0] c_RX_LAST   = c_BW'(SAMPLE_BITS - 1);

  logic [c_DW-1:0]        div_cnt_q, div_cnt_d;
  logic                   bclk_q, bclk_d;
  logic                   lrck_q, lrck_d;
  logic [c_BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_BITS-2:0] tx_rem_q, tx_rem_d;
  logic                   dacdat_q, dacdat_d;
  logic [SAMPLE_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                   rx_done_q, rx_done_d;
  logic [SAMPLE_BITS-1:0] audio_input_q, audio_input_d;
  logic                   channel_q, channel_d;
  logic                   sample_end_q, sample_end_d;
  logic                   sample_req_q, sample_req_d;

  logic w_wrap;
  logic w_rise;
  logic w_fall;
  logic w_rx_bit;

`ifdef CODEC_LOOPBACK_EN
  assign w_rx_bit = loopback ? dacdat_q : bus.AUD_ADCDAT;
`else
  assign w_rx_bit = bus.AUD_ADCDAT;
`endif

  assign w_wrap = (div_cnt_q == c_DIV_LAST);
  assign w_rise = w_wrap & ~bclk_q;
  assign w_fall = w_wrap &  bclk_q;

  always_comb begin
    div_cnt_d     = w_wrap ? '0 : div_cnt_q + 1'b1;
    bclk_d        = w_wrap ? ~bclk_q : bclk_q;
    lrck_d        = lrck_q;
    bit_cnt_d     = bit_cnt_q;
    tx_rem_d      = tx_rem_q;
    dacdat_d      = dacdat_q;
    rx_shift_d    = rx_shift_q;
    rx_done_d     = 1'b0;
    audio_input_d = audio_input_q;
    channel_d     = channel_q;
    sample_end_d  = 1'b0;
    sample_req_d  = 1'b0;

    if (w_fall) begin
      if (bit_cnt_q == c_SLOT_LAST) begin
        bit_cnt_d = '0;
        lrck_d    = ~lrck_q;
        tx_rem_d  = bus.audio_output[SAMPLE_BITS-2:0];
        dacdat_d  = bus.audio_output[SAMPLE_BITS-1];
      end else begin
        // MSB already on the pin, so only the remaining bits are held
        bit_cnt_d    = bit_cnt_q + 1'b1;
        tx_rem_d     = {tx_rem_q[SAMPLE_BITS-3:0], 1'b0};
        dacdat_d     = tx_rem_q[SAMPLE_BITS-2];
        sample_req_d = (bit_cnt_q == c_REQ_AT);
      end
    end

    if (w_rise && (bit_cnt_q < c_RX_BITS)) begin
      rx_shift_d = {rx_shift_q[SAMPLE_BITS-2:0], w_rx_bit};
      rx_done_d  = (bit_cnt_q == c_RX_LAST);
    end

    if (rx_done_q) begin
      audio_input_d = rx_shift_q;
      channel_d     = lrck_q;
      sample_end_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q     <= '0;
      bclk_q        <= 1'b0;
      lrck_q        <= 1'b0;
      bit_cnt_q     <= c_SLOT_LAST;
      tx_rem_q      <= '0;
      dacdat_q      <= 1'b0;
      rx_shift_q    <= '0;
      rx_done_q     <= 1'b0;
      audio_input_q <= '0;
      channel_q     <= 1'b0;
      sample_end_q  <= 1'b0;
      sample_req_q  <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      bclk_q        <= bclk_d;
      lrck_q        <= lrck_d;
      bit_cnt_q     <= bit_cnt_d;
      tx_rem_q      <= tx_rem_d;
      dacdat_q      <= dacdat_d;
      rx_shift_q    <= rx_shift_d;
      rx_done_q     <= rx_done_d;
      audio_input_q <= audio_input_d;
      channel_q     <= channel_d;
      sample_end_q  <= sample_end_d;
      sample_req_q  <= sample_req_d;
    end
  end

  assign bus.AUD_BCLK    = bclk_q;
  assign bus.AUD_DACLRCK = lrck_q;
  assign bus.AUD_ADCLRCK = lrck_q;
  assign bus.AUD_DACDAT  = dacdat_q;
  assign bus.audio_input = audio_input_q;
  assign bus.channel     = channel_q;
  assign bus.sample_end  = sample_end_q;
  assign bus.sample_req  = sample_req_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_codec_link.sv
`default_nettype none
// ==================================================================
// tb_audio_codec_link : random stimulus against a cycle-indexed link model
// Rev 1.0
// ==================================================================
module tb_audio_codec_link;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic loopback = 1'b0;

  always #5 clk = ~clk;

  audio_codec_link_if #(.SAMPLE_BITS(16)) bus ();

  audio_codec_link dut (
    .clk      (clk),
    .reset    (reset),
`ifdef CODEC_LOOPBACK_EN
    .loopback (loopback),
`endif
    .bus      (bus)
  );

  int checks = 0;
  int failures = 0;

  // Model state: t = clk edges since the last reset edge
  int          t = 0;
  logic [15:0] m_word = '0;
  logic [15:0] m_acc = '0;
  logic        m_pend = 1'b0;
  logic [15:0] m_pend_word = '0;
  logic        m_pend_ch = 1'b0;
  logic [15:0] e_ain = '0;
  logic        e_ch = 1'b0, e_end = 1'b0, e_req = 1'b0, e_dac = 1'b0;
  logic        e_bclk = 1'b0, e_lrck = 1'b0;

  // Observation logs for scenario checks
  int          req_cnt = 0;
  int          first_lr_t = -1;
  logic        cap_en = 1'b0;
  logic [31:0] dac_cap = '0;
  logic [15:0] rx_ain_q[$];
  logic        rx_ch_q[$];
  logic        scripted_adc = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  function automatic logic [22:0] pack_outs();
    return {bus.audio_input, bus.channel, bus.sample_end, bus.sample_req,
            bus.AUD_DACDAT, bus.AUD_BCLK, bus.AUD_DACLRCK, bus.AUD_ADCLRCK};
  endfunction

  // One clk edge: advance the model with the inputs present at the edge, compare
  task automatic step();
    int   k, j;
    logic fall, rise, lb, rbit;
    @(posedge clk);
    #1;
    fall = 1'b0;
    k = 0;
`ifdef CODEC_LOOPBACK_EN
    lb = loopback;
`else
    lb = 1'b0;
`endif
    if (reset) begin
      t = 0; m_acc = '0; m_pend = 1'b0;
      e_ain = '0; e_ch = 1'b0; e_end = 1'b0; e_req = 1'b0; e_dac = 1'b0;
      dac_cap = '0;
    end else begin
      t++;
      e_end = m_pend;
      if (m_pend) begin
        e_ain = m_pend_word;
        e_ch  = m_pend_ch;
      end
      m_pend = 1'b0;
      e_req = 1'b0;
      k = t / 8;
      fall = (t >= 8) && (t % 8 == 0);
      rise = (t % 8 == 4) && (k >= 1);
      if (fall) begin
        j = (k - 1) % 32;
        if (j == 0) m_word = bus.audio_output;
        e_dac = (j < 16) ? m_word[15-j] : 1'b0;
        e_req = (j == 31);
      end
      if (rise) begin
        j = (k - 1) % 32;
        if (j < 16) begin
          rbit  = lb ? e_dac : bus.AUD_ADCDAT;
          m_acc = {m_acc[14:0], rbit};
          if (j == 15) begin
            m_pend      = 1'b1;
            m_pend_word = m_acc;
            m_pend_ch   = (((k - 1) / 32) % 2) == 0;
          end
        end
      end
    end
    e_bclk = ((t / 4) % 2) == 1;
    e_lrck = (t < 8) ? 1'b0 : ((((t / 8 - 1) / 32) % 2) == 0);
    check_val("outs", 32'(pack_outs()),
              32'({e_ain, e_ch, e_end, e_req, e_dac, e_bclk, e_lrck, e_lrck}));

    if (bus.sample_req) req_cnt++;
    if (bus.sample_end) begin
      rx_ain_q.push_back(bus.audio_input);
      rx_ch_q.push_back(bus.channel);
    end
    if (cap_en && !reset && fall && k >= 1 && k <= 32)
      dac_cap = {dac_cap[30:0], bus.AUD_DACDAT};
    if (!reset && bus.AUD_DACLRCK && first_lr_t < 0) first_lr_t = t;
  endtask

  // Drive ADCDAT for the next edge: scripted words in slots 0/1, random otherwise
  task automatic drive_adc();
    int          nt, j, s;
    logic [15:0] w0, w1;
    w0 = 16'h8001;
    w1 = 16'h7FFE;
    nt = t + 1;
    bus.AUD_ADCDAT = 1'($urandom);
    if (scripted_adc && (nt % 8 == 4) && (nt / 8 >= 1)) begin
      j = (nt / 8 - 1) % 32;
      s = (nt / 8 - 1) / 32;
      if (j < 16 && s == 0) bus.AUD_ADCDAT = w0[15-j];
      if (j < 16 && s == 1) bus.AUD_ADCDAT = w1[15-j];
    end
  endtask

  initial begin
    logic [15:0] w;
    int          early_ends;
    bit          found;

    bus.audio_output = 16'h0;
    bus.AUD_ADCDAT   = 1'b0;

    // Reset held: everything quiet
    for (int i = 0; i < 20; i++) step();
    check_val("reset_outs", 32'(pack_outs()), 32'h0);

    // Fixed word, scripted ADC, four frames
    bus.audio_output = 16'hA5C3;
    reset = 1'b0;
    cap_en = 1'b1;
    scripted_adc = 1'b1;
    req_cnt = 0;
    rx_ain_q.delete();
    rx_ch_q.delete();
    drive_adc();
    for (int i = 0; i < 2048; i++) begin
      step();
      drive_adc();
    end
    cap_en = 1'b0;
    scripted_adc = 1'b0;
    check_val("lrck_first_rise", 32'(first_lr_t), 32'd8);
    check_val("dac_slot0", dac_cap, 32'hA5C3_0000);
    check_val("req_count_4frames", 32'(req_cnt), 32'd8);
    if (rx_ain_q.size() >= 2) begin
      check_val("rx_left_word", 32'(rx_ain_q[0]), 32'h8001);
      check_val("rx_left_ch", 32'(rx_ch_q[0]), 32'h1);
      check_val("rx_right_word", 32'(rx_ain_q[1]), 32'h7FFE);
      check_val("rx_right_ch", 32'(rx_ch_q[1]), 32'h0);
    end else begin
      check_val("rx_event_count", 32'(rx_ain_q.size()), 32'd2);
    end

    // Random words changing every clk, random ADC
    for (int i = 0; i < 1024; i++) begin
      bus.audio_output = 16'($urandom);
      step();
      drive_adc();
    end

    // Reset for one clk right after bit_cnt reaches 7
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      bus.audio_output = 16'($urandom);
      drive_adc();
      step();
      if (t >= 8 && t % 8 == 0 && ((t / 8 - 1) % 32) == 7) found = 1'b1;
    end
    check_val("reset_point_found", 32'(found), 32'h1);
    w = 16'($urandom);
    bus.audio_output = w;
    reset = 1'b1;
    cap_en = 1'b1;
    step();
    check_val("mid_reset_outs", 32'(pack_outs()), 32'h0);
    reset = 1'b0;
    rx_ain_q.delete();
    rx_ch_q.delete();
    early_ends = -1;
    for (int i = 0; i < 300; i++) begin
      drive_adc();
      step();
      if (t == 132) early_ends = rx_ain_q.size();
      if (t > 16) bus.audio_output = 16'($urandom);
    end
    cap_en = 1'b0;
    check_val("no_partial_end", 32'(early_ends), 32'd0);
    check_val("dac_after_reset", dac_cap, {w, 16'h0});

`ifdef CODEC_LOOPBACK_EN
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    loopback = 1'b1;
    bus.audio_output = 16'h1234;
    bus.AUD_ADCDAT = 1'b0;
    rx_ain_q.delete();
    rx_ch_q.delete();
    for (int i = 0; i < 1100; i++) step();
    check_val("lb_event_count", 32'(rx_ain_q.size() >= 4), 32'h1);
    foreach (rx_ain_q[i]) check_val("lb_word", 32'(rx_ain_q[i]), 32'h1234);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
